mig_rd_checker: RTL
===================

Name: mig_rd_checker

Overview:
Downstream consumer of the MIG user-interface read-data channel. Checks each returned read beat against the expected byte-replicated counter pattern that the write generator produced. Reports per-beat compare errors, a saturating error count, the first failing beat, and a run-level pass/fail/timeout verdict. Sits in the ui_clk domain between mig_7series_0 app_rd_* outputs and the debug/LED logic.

Parameters:
APP_DATA_WIDTH, 128, width of app_rd_data; must be a multiple of 8
BEAT_W, 24, width of beat count/index
ERR_W, 16, width of saturating error counter
TIMEOUT_CYC, 65535, max ui_clk cycles between beats in RUN before a timeout is declared

Ports:
ui_clk  input  1  MIG user-interface clock; all logic on rising edge
ui_rst  input  1  asynchronous, active-high reset
start_i  input  1  single-cycle pulse; arms a check run (honoured only in IDLE)
beats_i  input  BEAT_W  number of read beats expected in the run; sampled on start_i
seed_i  input  8  pattern byte for beat 0; sampled on start_i
app_rd_data  input  APP_DATA_WIDTH  MIG read data
app_rd_data_valid  input  1  MIG read data valid
busy_o  output  1  high in RUN
done_o  output  1  one-cycle pulse when a run ends
pass_o  output  1  run verdict: no errors, no timeout, all beats received
timeout_o  output  1  run ended by timeout
tg_compare_error  output  1  one-cycle pulse per mismatching beat
err_cnt_o  output  ERR_W  mismatching beats in current/last run, saturating
first_err_idx_o  output  BEAT_W  beat index of first mismatch
first_err_data_o  output  APP_DATA_WIDTH  data of first mismatching beat
first_err_vld_o  output  1  first_err_* fields valid
stray_o  output  1  sticky: a valid beat arrived outside RUN; cleared by start_i

Behaviour:
- Reset (async, ui_rst=1): state IDLE; all outputs 0; internal counters/registers 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_i=1 -> latch beats_i, seed_i; clear err_cnt_o, first_err_*, pass_o, timeout_o, stray_o, beat index, idle timer; go RUN. If beats_i==0 -> go DONE directly (pass_o=1).
- RUN: each cycle with app_rd_data_valid=1 is one beat; beat index increments (BEAT_W, no wrap needed since bounded by beats). Idle timer clears on a beat, else increments; timer==TIMEOUT_CYC-1 with no beat -> timeout_o=1, go DONE. Beat with index==beats-1 -> go DRAIN.
- DRAIN: waits until the compare pipeline is empty (2 cycles), then DONE. Beats arriving in DRAIN are treated as stray.
- DONE: done_o=1 for exactly one cycle; pass_o = (err_cnt==0) && !timeout; go IDLE. pass_o, timeout_o, err_cnt_o, first_err_* hold until next start_i.
- Expected data for beat k: byte (seed + k[7:0]) mod 256 replicated APP_DATA_WIDTH/8 times.
- Pipeline: stage 1 registers data, valid, expected byte; stage 2 registers compare result. tg_compare_error pulses exactly 2 ui_clk cycles after the beat's valid cycle. Error counting and first-error capture are updated in the same cycle as that pulse.
- err_cnt_o saturates at all-ones; it never wraps.
- first_err_* are captured only on the first mismatch of a run; later mismatches do not overwrite them.
- start_i in RUN/DRAIN/DONE: ignored. Valid outside RUN: stray_o=1, no compare, no count.
- busy_o=1 in RUN and DRAIN.
- ui_rst mid-run: immediate return to reset values; no done_o.

Decomposition:
- Shared package mig_test_pkg: state encodings, CMD_WRITE/CMD_READ constants, pattern-byte function (seed + index -> replicated word), shared with the write generator so both sides use one pattern definition.
- Sub-module mig_rd_cmp_pipe: the two-stage register/compare pipeline (data in, expected byte in -> mismatch pulse, delayed index, delayed data).

Test Plan:
1. start_i with beats=1000, seed=0x00; feed 1000 correct beats with back-to-back valid -> done_o 1 pulse, pass_o=1, err_cnt_o=0, tg_compare_error never high.
2. beats=300, seed=0xF0; corrupt beats 5 and 260 (byte 0 flipped) -> tg_compare_error pulses 2 cycles after each bad beat; err_cnt_o=2; first_err_idx_o=5; pass_o=0. Beat 16 expects 0x00, confirming pattern wrap.
3. beats=10, only 6 beats sent, TIMEOUT_CYC=100 -> done_o at 100 idle cycles after beat 6; timeout_o=1, pass_o=0.
4. ERR_W=4, beats=40, all beats corrupted -> err_cnt_o saturates at 15; first_err_idx_o=0.
5. Valid pulse in IDLE -> stray_o=1, err_cnt_o unchanged. Next start_i clears stray_o. A start_i pulse mid-RUN is ignored (beat count unchanged).
6. beats=0 -> done_o 1 cycle after start_i, pass_o=1. Separately, assert ui_rst mid-RUN -> all outputs 0 asynchronously and no done_o.

Source files
------------

// File: rtl/mig_test_pkg.sv
// rtl/mig_test_pkg.sv - shared encodings and test-pattern definition for the MIG traffic generator/checker
package mig_test_pkg;

   localparam int MAX_DATA_W = 1024;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_e;

   // Beat k of a run carries byte (seed + k) mod 256 in every byte lane.
   function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [7:0] idx);
      return seed + idx;
   endfunction

   function automatic logic [MAX_DATA_W-1:0] pattern_word(input logic [7:0] seed, input logic [7:0] idx);
      return {(MAX_DATA_W/8){pattern_byte(seed, idx)}};
   endfunction

   // Lanes at or above nbytes are padding and never compared.
   function automatic logic pattern_match(input logic [MAX_DATA_W-1:0] data, input int nbytes,
                                          input logic [7:0] b);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MAX_DATA_W/8; i++) begin
         if (i < nbytes && data[i*8 +: 8] != b) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/mig_rd_cmp_pipe.sv
// rtl/mig_rd_cmp_pipe.sv - two-stage register/compare pipeline for returned read beats
module mig_rd_cmp_pipe
   import mig_test_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int IDX_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vld_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [7:0]        exp_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic              fail_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic [DATA_W-1:0] data_o,
   output logic              mismatch_o
);

   logic              s1_vld_q,  s1_vld_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [7:0]        s1_exp_q,  s1_exp_d;
   logic [IDX_W-1:0]  s1_idx_q,  s1_idx_d;
   logic              mis_q,     mis_d;
   logic              fail;

   always_comb begin
      s1_vld_d  = vld_i;
      s1_data_d = s1_data_q;
      s1_exp_d  = s1_exp_q;
      s1_idx_d  = s1_idx_q;
      if (vld_i) begin
         s1_data_d = data_i;
         s1_exp_d  = exp_i;
         s1_idx_d  = idx_i;
      end
      // fail is what stage 2 captures on the next edge; the parent counts errors off it
      fail  = s1_vld_q && !pattern_match(MAX_DATA_W'(s1_data_q), DATA_W/8, s1_exp_q);
      mis_d = fail;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_exp_q  <= '0;
         s1_idx_q  <= '0;
         mis_q     <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_exp_q  <= s1_exp_d;
         s1_idx_q  <= s1_idx_d;
         mis_q     <= mis_d;
      end
   end

   assign fail_o     = fail;
   assign idx_o      = s1_idx_q;
   assign data_o     = s1_data_q;
   assign mismatch_o = mis_q;

endmodule

// File: rtl/mig_rd_checker.sv
// rtl/mig_rd_checker.sv - MIG read-data checker: compares returned beats against the counter pattern
module mig_rd_checker
   import mig_test_pkg::*;
#(
   parameter int APP_DATA_WIDTH = 128,
   parameter int BEAT_W         = 24,
   parameter int ERR_W          = 16,
   parameter int TIMEOUT_CYC    = 65535
) (
   input  logic                      ui_clk,
   input  logic                      ui_rst,
   input  logic                      start_i,
   input  logic [BEAT_W-1:0]         beats_i,
   input  logic [7:0]                seed_i,
   input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
   input  logic                      app_rd_data_valid,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      pass_o,
   output logic                      timeout_o,
   output logic                      tg_compare_error,
   output logic [ERR_W-1:0]          err_cnt_o,
   output logic [BEAT_W-1:0]         first_err_idx_o,
   output logic [APP_DATA_WIDTH-1:0] first_err_data_o,
   output logic                      first_err_vld_o,
   output logic                      stray_o
);

   localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   chk_state_e                state_q, state_d;
   logic [BEAT_W-1:0]         beats_q, beats_d;
   logic [7:0]                seed_q, seed_d;
   logic [BEAT_W-1:0]         idx_q, idx_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic                      drain_q, drain_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      pass_q, pass_d;
   logic                      timeout_q, timeout_d;
   logic [ERR_W-1:0]          err_cnt_q, err_cnt_d;
   logic [BEAT_W-1:0]         fidx_q, fidx_d;
   logic [APP_DATA_WIDTH-1:0] fdata_q, fdata_d;
   logic                      fvld_q, fvld_d;
   logic                      stray_q, stray_d;

   logic                      beat;
   logic [7:0]                exp_byte;
   logic                      cmp_fail;
   logic [BEAT_W-1:0]         cmp_idx;
   logic [APP_DATA_WIDTH-1:0] cmp_data;
   logic                      cmp_mis;

   assign beat     = app_rd_data_valid && (state_q == ST_RUN);
   assign exp_byte = pattern_byte(seed_q, idx_q[7:0]);

   mig_rd_cmp_pipe #(
      .DATA_W (APP_DATA_WIDTH),
      .IDX_W  (BEAT_W)
   ) u_cmp (
      .clk        (ui_clk),
      .rst        (ui_rst),
      .vld_i      (beat),
      .data_i     (app_rd_data),
      .exp_i      (exp_byte),
      .idx_i      (idx_q),
      .fail_o     (cmp_fail),
      .idx_o      (cmp_idx),
      .data_o     (cmp_data),
      .mismatch_o (cmp_mis)
   );

   always_comb begin
      state_d   = state_q;
      beats_d   = beats_q;
      seed_d    = seed_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      drain_d   = drain_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      err_cnt_d = err_cnt_q;
      fidx_d    = fidx_q;
      fdata_d   = fdata_q;
      fvld_d    = fvld_q;
      stray_d   = stray_q;

      // Error bookkeeping lands on the same edge as the stage-2 mismatch flop.
      if (cmp_fail) begin
         if (!(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
         if (!fvld_q) begin
            fvld_d  = 1'b1;
            fidx_d  = cmp_idx;
            fdata_d = cmp_data;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               beats_d   = beats_i;
               seed_d    = seed_i;
               idx_d     = '0;
               timer_d   = '0;
               err_cnt_d = '0;
               fidx_d    = '0;
               fdata_d   = '0;
               fvld_d    = 1'b0;
               timeout_d = 1'b0;
               stray_d   = 1'b0;
               if (beats_i == '0) begin
                  state_d = ST_DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  pass_d  = 1'b0;
               end
            end
         end
         ST_RUN: begin
            if (beat) begin
               idx_d   = idx_q + BEAT_W'(1);
               timer_d = '0;
               if (idx_q == beats_q - BEAT_W'(1)) begin
                  state_d = ST_DRAIN;
                  drain_d = 1'b0;
               end
            end else if (timer_q == TMR_LAST) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = ST_DONE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_DRAIN: begin
            // Two cycles let the final beat's compare result reach the error counter.
            if (drain_q) begin
               state_d = ST_DONE;
               pass_d  = (err_cnt_d == '0) && !timeout_q;
            end else begin
               drain_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (app_rd_data_valid && state_q != ST_RUN) begin
         stray_d = 1'b1;
      end

      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         state_q   <= ST_IDLE;
         beats_q   <= '0;
         seed_q    <= '0;
         idx_q     <= '0;
         timer_q   <= '0;
         drain_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         err_cnt_q <= '0;
         fidx_q    <= '0;
         fdata_q   <= '0;
         fvld_q    <= 1'b0;
         stray_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         beats_q   <= beats_d;
         seed_q    <= seed_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
         drain_q   <= drain_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         err_cnt_q <= err_cnt_d;
         fidx_q    <= fidx_d;
         fdata_q   <= fdata_d;
         fvld_q    <= fvld_d;
         stray_q   <= stray_d;
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign timeout_o        = timeout_q;
   assign tg_compare_error = cmp_mis;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_idx_o  = fidx_q;
   assign first_err_data_o = fdata_q;
   assign first_err_vld_o  = fvld_q;
   assign stray_o          = stray_q;

endmodule
